// File: rtl/dif_pkg.sv
// Shared types and constants for the pipelined 16-bit subtractor.
// SUB_FLAGS_EN adds the sign bits that the zero/overflow flags need.
package dif_pkg;

    localparam int WIDTH = 16;
    localparam int HALF  = WIDTH / 2;

    typedef struct packed {
        logic [HALF-1:0] lo_dif;
        logic            carry;
        logic [HALF-1:0] hi_a;
        logic [HALF-1:0] hi_b;
`ifdef SUB_FLAGS_EN
        logic            sign_a;
        logic            sign_b;
`endif
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] dif;
        logic             borrow;
        logic             zero;
        logic             ovf;
    } res_t;

endpackage

// File: rtl/cla_8bit.sv
// Combinational 8-bit carry look-ahead adder.
// Each carry is the flattened generate/propagate sum of products.
module cla_8bit
    import dif_pkg::*;
(
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    input  logic            cin,
    output logic [HALF-1:0] s,
    output logic            cout
);

    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    logic            acc;
    logic            pp;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < HALF; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign s    = p ^ c[HALF-1:0];
    assign cout = c[HALF];

endmodule

// File: rtl/dif_16bit_pipe.sv
// Two-stage byte-sliced 16-bit subtractor with valid/ready handshake.
// Define SUB_FLAGS_EN to register the zero and signed-overflow flags.
module dif_16bit_pipe
    import dif_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] nr1,
    input  logic [WIDTH-1:0] nr2,
    input  logic             borrow_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dif,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    s1_t  s1_q;
    s1_t  s1_d;
    res_t res_q;
    res_t res_d;
    logic s1_valid;
    logic s2_valid;
    logic s2_load;
    logic s1_adv;
    logic accept;

    logic [HALF-1:0] lo_sum;
    logic            lo_cout;
    logic [HALF-1:0] hi_sum;
    logic            hi_cout;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // Subtraction as a + ~b + !borrow_in, low byte first.
    cla_8bit u_lo (
        .a    (nr1[HALF-1:0]),
        .b    (~nr2[HALF-1:0]),
        .cin  (~borrow_in),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    always_comb begin
        s1_d        = '0;
        s1_d.lo_dif = lo_sum;
        s1_d.carry  = lo_cout;
        s1_d.hi_a   = nr1[WIDTH-1:HALF];
        s1_d.hi_b   = nr2[WIDTH-1:HALF];
`ifdef SUB_FLAGS_EN
        s1_d.sign_a = nr1[WIDTH-1];
        s1_d.sign_b = nr2[WIDTH-1];
`endif
    end

    cla_8bit u_hi (
        .a    (s1_q.hi_a),
        .b    (~s1_q.hi_b),
        .cin  (s1_q.carry),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    always_comb begin
        res_d        = '0;
        res_d.dif    = {hi_sum, s1_q.lo_dif};
        res_d.borrow = ~hi_cout;
`ifdef SUB_FLAGS_EN
        res_d.zero   = (res_d.dif == '0);
        res_d.ovf    = (s1_q.sign_a != s1_q.sign_b) &&
                       (hi_sum[HALF-1] != s1_q.sign_a);
`else
        res_d.zero   = 1'b0;
        res_d.ovf    = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_valid <= accept || (s1_valid && !s1_adv);
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // Data only moves on s1_adv so a bubble leaves the last result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            res_q    <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = s2_valid;
    assign dif       = res_q.dif;
    assign borrow    = res_q.borrow;
    assign zero      = res_q.zero;
    assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_dif_16bit_pipe.sv
// Directed bench for dif_16bit_pipe; flag expectations follow SUB_FLAGS_EN.
module tb_dif_16bit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nr1;
    logic [15:0] nr2;
    logic        borrow_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dif;
    logic        borrow;
    logic        zero;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [15:0] dif;
        logic        borrow;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t        exq[$];
    int          vec_cnt  = 0;
    int          err_cnt  = 0;
    int          acc_cnt  = 0;
    int          xfer_cnt = 0;
    bit          held_v   = 1'b0;
    logic [15:0] held_dif;

`ifdef SUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    dif_16bit_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .nr1       (nr1),
        .nr2       (nr2),
        .borrow_in (borrow_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dif       (dif),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic bi);
        exp_t        r;
        logic [16:0] d;
        d        = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        r.dif    = d[15:0];
        r.borrow = d[16];
        r.zero   = FL && (d[15:0] == 16'd0);
        r.ovf    = FL && (a[15] != b[15]) && (d[15] != a[15]);
        return r;
    endfunction

    // One cycle: drive at the falling edge, judge transfers 1 ns later.
    task automatic cycle(input bit v, input logic [15:0] a,
                         input logic [15:0] b, input bit bi,
                         input bit ordy);
        exp_t e;
        in_valid  = v;
        nr1       = a;
        nr2       = b;
        borrow_in = bi;
        out_ready = ordy;
        #1;
        if (held_v && out_valid)
            check("hold_dif", dif, held_dif);
        held_v   = out_valid && !out_ready;
        held_dif = dif;
        if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exq.size() == 0) begin
                check("extra_result", 1, 0);
            end else begin
                e = exq.pop_front();
                check("dif", dif, e.dif);
                check("borrow", borrow, e.borrow);
                check("zero", zero, e.zero);
                check("ovf", ovf, e.ovf);
            end
        end
        if (in_valid && in_ready) begin
            acc_cnt++;
            exq.push_back(model(a, b, bi));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exq.size() != 0; i++)
            cycle(0, 16'd0, 16'd0, 0, 1);
        check("drain_empty", exq.size(), 0);
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input bit bi, input logic [15:0] xd, input bit xb,
                      input bit xz, input bit xo);
        cycle(1, a, b, bi, 1);
        check("lat_edge1", out_valid, 0);
        cycle(0, 16'd0, 16'd0, 0, 1);
        check("lat_edge2", out_valid, 1);
        check("op_dif", dif, xd);
        check("op_borrow", borrow, xb);
        check("op_zero", zero, xz && FL);
        check("op_ovf", ovf, xo && FL);
        drain();
    endtask

    initial begin
        int a0;
        int x0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        nr1       = '0;
        nr2       = '0;
        borrow_in = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dif", dif, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(16'd200, 16'd50, 1, 16'd149, 0, 0, 0);
        op(16'd1, 16'd1, 0, 16'd0, 0, 1, 0);
        op(16'd0, 16'd1, 0, 16'hFFFF, 1, 0, 0);
        op(16'h8000, 16'd1, 0, 16'h7FFF, 0, 0, 1);

        // Six back-to-back ops must finish within 8 cycles.
        x0 = xfer_cnt;
        for (int k = 0; k < 6; k++)
            cycle(1, 16'd30000, 16'(k), 0, 1);
        cycle(0, 16'd0, 16'd0, 0, 1);
        cycle(0, 16'd0, 16'd0, 0, 1);
        check("b2b_results", xfer_cnt - x0, 6);
        check("b2b_empty", exq.size(), 0);

        a0 = acc_cnt;
        x0 = xfer_cnt;
        for (int i = 0; i < 4; i++)
            cycle(1, 16'(1000 + acc_cnt - a0), 16'd7, 0, 0);
        check("stall_accepts", acc_cnt - a0, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_dif", dif, 16'd993);
        drain();
        check("stall_results", xfer_cnt - x0, 2);

        cycle(1, 16'd5, 16'd1, 0, 0);
        cycle(1, 16'd6, 16'd1, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exq.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        op(16'd562, 16'd364, 0, 16'd198, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt,
                 err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
